// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: snoops a 4-bit HD44780-style LCD bus (LCD_D = {RS, nibble},
// LCD_E strobe). It follows the 8-bit to 4-bit init handshake, pairs nibbles
// into bytes, reports instructions and character writes, and keeps a mirror of
// the DDRAM address counter so every character carries its screen position.
//
// Handshake: the bus has no ready. A nibble is accepted on every falling edge
// of the synchronized LCD_E; the value is whatever sync LCD_D held during the
// last cycle sync LCD_E was high. Each output pulse (char_valid, cmd_valid,
// clear_pulse, frame_error) is high for exactly one cycle, and the data fields
// that go with it hold until the next pulse.
module lcd_bus_receiver #(
  parameter int NIBBLE_TIMEOUT = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] LCD_D,
  input  logic       LCD_E,
  output logic       char_valid,
  output logic [7:0] char_data,
  output logic [6:0] char_addr,
  output logic       char_visible,
  output logic       cmd_valid,
  output logic [7:0] cmd_data,
  output logic       clear_pulse,
  output logic       mode4,
  output logic       frame_error,
  output logic [1:0] fsm_state
);

  localparam int TW = (NIBBLE_TIMEOUT < 2) ? 1 : $clog2(NIBBLE_TIMEOUT + 1);

  localparam logic [1:0] ST_INIT8  = 2'd0;
  localparam logic [1:0] ST_NIB_HI = 2'd1;
  localparam logic [1:0] ST_NIB_LO = 2'd2;

  logic          e_s1, e_s2, e_prev;
  logic [4:0]    d_s1, d_s2, cap;
  logic          fall;
  logic [1:0]    state;
  logic [4:0]    hi_nib;
  logic [TW-1:0] tcnt;
  logic [6:0]    addr;
  logic          dir_inc;
  logic [7:0]    rx_byte;

  // Next DDRAM address, following the two 40-cell line segments.
  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  // Set-address targets in the gaps snap to the start of their line.
  function automatic logic [6:0] addr_clamp(input logic [6:0] a);
    logic [6:0] r;
    if (a >= 7'h28 && a <= 7'h3F) r = 7'h00;
    else if (a >= 7'h68)          r = 7'h40;
    else                          r = a;
    return r;
  endfunction

  // 16x2 visible window: first 16 cells of each line.
  function automatic logic addr_visible(input logic [6:0] a);
    return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
  endfunction

  assign fall      = e_prev && !e_s2;
  assign rx_byte   = {hi_nib[3:0], cap[3:0]};
  assign fsm_state = state;

  // Two-flop synchronizer for the bus, edge history, and nibble capture.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      e_s1   <= 1'b0;
      e_s2   <= 1'b0;
      e_prev <= 1'b0;
      d_s1   <= 5'd0;
      d_s2   <= 5'd0;
      cap    <= 5'd0;
    end else begin
      e_s1   <= LCD_E;
      e_s2   <= e_s1;
      e_prev <= e_s2;
      d_s1   <= LCD_D;
      d_s2   <= d_s1;
      if (e_s2) cap <= d_s2;
    end
  end

  // Protocol FSM: init handshake, nibble pairing, timeout and byte dispatch.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_INIT8;
      hi_nib       <= 5'd0;
      tcnt         <= '0;
      addr         <= 7'h00;
      dir_inc      <= 1'b1;
      mode4        <= 1'b0;
      char_valid   <= 1'b0;
      char_data    <= 8'h00;
      char_addr    <= 7'h00;
      char_visible <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_data     <= 8'h00;
      clear_pulse  <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      char_valid  <= 1'b0;
      cmd_valid   <= 1'b0;
      clear_pulse <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        ST_INIT8: begin
          // Only "function set, 4-bit" moves on; 0x3 and anything else stay.
          if (fall && !cap[4] && cap[3:0] == 4'h2) begin
            state <= ST_NIB_HI;
            mode4 <= 1'b1;
          end
        end
        ST_NIB_HI: begin
          if (fall) begin
            hi_nib <= cap;
            tcnt   <= '0;
            state  <= ST_NIB_LO;
          end
        end
        ST_NIB_LO: begin
          // A low nibble arriving on the expiry cycle still wins.
          if (fall) begin
            state <= ST_NIB_HI;
            if (hi_nib[4]) begin
              char_valid   <= 1'b1;
              char_data    <= rx_byte;
              char_addr    <= addr;
              char_visible <= addr_visible(addr);
              addr         <= addr_step(addr, dir_inc);
            end else begin
              cmd_valid <= 1'b1;
              cmd_data  <= rx_byte;
              if (rx_byte == 8'h01) begin
                addr        <= 7'h00;
                dir_inc     <= 1'b1;
                clear_pulse <= 1'b1;
              end else if (rx_byte[7:1] == 7'b0000001) begin
                addr <= 7'h00;
              end else if (rx_byte[7:2] == 6'b000001) begin
                dir_inc <= rx_byte[1];
              end else if (rx_byte[7:4] == 4'h3) begin
                mode4 <= 1'b0;
                state <= ST_INIT8;
              end else if (rx_byte[7]) begin
                addr <= addr_clamp(rx_byte[6:0]);
              end
            end
          end else if (tcnt >= TW'(NIBBLE_TIMEOUT)) begin
            frame_error <= 1'b1;
            hi_nib      <= 5'd0;
            state       <= ST_NIB_HI;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= ST_INIT8;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb_lcd_bus_receiver: drives nibble transfers on the LCD bus and checks the
// receiver against a screen-position model built from linear cell indices.
module tb_lcd_bus_receiver;

  localparam int TO = 300;

  logic       CLK;
  logic       RESET;
  logic [4:0] LCD_D;
  logic       LCD_E;
  logic       char_valid;
  logic [7:0] char_data;
  logic [6:0] char_addr;
  logic       char_visible;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       clear_pulse;
  logic       mode4;
  logic       frame_error;
  logic [1:0] fsm_state;

  lcd_bus_receiver #(.NIBBLE_TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .LCD_D(LCD_D), .LCD_E(LCD_E),
    .char_valid(char_valid), .char_data(char_data), .char_addr(char_addr),
    .char_visible(char_visible), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .clear_pulse(clear_pulse), .mode4(mode4), .frame_error(frame_error),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_char_q[$];   // {data, addr, visible}
  logic [15:0] obs_char_q[$];
  logic [7:0]  exp_cmd_q[$];
  logic [7:0]  obs_cmd_q[$];
  int exp_clr, obs_clr, exp_fe, obs_fe;
  int n_vec, n_err;

  // ---------------- reference model ----------------
  bit         m_mode4;
  bit         m_inc;
  bit         m_hi_pend;
  bit         m_hi_rs;
  logic [3:0] m_hi;
  logic [6:0] m_addr;

  // Screen cell index 0..79: line 1 cells 0..39, line 2 cells 40..79.
  function automatic int cell_of(input logic [6:0] a);
    return (a < 7'h40) ? int'(a) : int'(a) - 64 + 40;
  endfunction

  function automatic logic [6:0] addr_of(input int idx);
    return (idx < 40) ? 7'(idx) : 7'(idx - 40 + 64);
  endfunction

  task automatic model_reset();
    m_mode4 = 0; m_inc = 1; m_hi_pend = 0; m_hi_rs = 0; m_hi = 4'h0; m_addr = 7'h00;
  endtask

  task automatic model_byte(input bit rs, input logic [7:0] b);
    int idx;
    if (rs) begin
      idx = cell_of(m_addr);
      exp_char_q.push_back({b, m_addr, 1'((idx % 40) < 16)});
      idx = m_inc ? (idx + 1) % 80 : (idx + 79) % 80;
      m_addr = addr_of(idx);
    end else begin
      exp_cmd_q.push_back(b);
      if (b == 8'h01) begin
        m_addr = 7'h00; m_inc = 1; exp_clr++;
      end else if (b == 8'h02 || b == 8'h03) begin
        m_addr = 7'h00;
      end else if (b >= 8'h04 && b <= 8'h07) begin
        m_inc = b[1];
      end else if (b >= 8'h30 && b <= 8'h3F) begin
        m_mode4 = 0;
      end else if (b >= 8'h80) begin
        m_addr = b[6:0];
        if (m_addr >= 7'h28 && m_addr <= 7'h3F) m_addr = 7'h00;
        else if (m_addr >= 7'h68) m_addr = 7'h40;
      end
    end
  endtask

  task automatic model_nibble(input bit rs, input logic [3:0] nib);
    if (!m_mode4) begin
      if (!rs && nib == 4'h2) m_mode4 = 1;
    end else if (!m_hi_pend) begin
      m_hi_pend = 1; m_hi_rs = rs; m_hi = nib;
    end else begin
      m_hi_pend = 0;
      model_byte(m_hi_rs, {m_hi, nib});
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (char_valid)  obs_char_q.push_back({char_data, char_addr, char_visible});
    if (cmd_valid)   obs_cmd_q.push_back(cmd_data);
    if (clear_pulse) obs_clr++;
    if (frame_error) obs_fe++;
  end

  // ---------------- drivers ----------------
  task automatic send_nibble(input bit rs, input logic [3:0] nib, input int gap);
    @(negedge CLK);
    LCD_D = {rs, nib};
    LCD_E = 1'b1;
    repeat ($urandom_range(2, 5)) @(negedge CLK);
    LCD_E = 1'b0;
    @(negedge CLK);
    LCD_D = 5'($urandom);
    repeat (gap) @(negedge CLK);
    model_nibble(rs, nib);
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b);
    send_nibble(rs, b[7:4], 8);
    send_nibble(rs, b[3:0], 8);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET = 1'b1; LCD_E = 1'b0; LCD_D = 5'd0;
    repeat (4) @(negedge CLK);
    n_vec++;
    if ({char_valid, char_data, char_addr, char_visible, cmd_valid, cmd_data,
         clear_pulse, mode4, frame_error} !== 29'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0", {char_valid, char_data, char_addr,
               char_visible, cmd_valid, cmd_data, clear_pulse, mode4, frame_error});
    end
    n_vec++;
    if (fsm_state !== 2'd0) begin
      n_err++; $display("FAIL reset_state: got %0d expected 0 (INIT8)", fsm_state);
    end
    RESET = 1'b0;
    model_reset();
    @(negedge CLK);
  endtask

  task automatic test_init();
    send_nibble(0, 4'h3, 8);
    send_nibble(0, 4'h3, 8);
    send_nibble(0, 4'h3, 8);
    n_vec++;
    if (mode4 !== 1'b0) begin n_err++; $display("FAIL init_mode4_pre: got %b expected 0", mode4); end
    send_nibble(0, 4'h2, 8);
    n_vec++;
    if (mode4 !== 1'b1) begin n_err++; $display("FAIL init_mode4: got %b expected 1", mode4); end
    send_byte(0, 8'h28);
    n_vec++;
    if (obs_cmd_q.size() != 1 || obs_cmd_q[0] !== 8'h28) begin
      n_err++; $display("FAIL init_cmd: got %0d cmds (first %h) expected one 28", obs_cmd_q.size(),
                        obs_cmd_q.size() ? obs_cmd_q[0] : 8'h00);
    end
    n_vec++;
    if (obs_char_q.size() != 0) begin n_err++; $display("FAIL init_no_char: got %0d chars expected 0", obs_char_q.size()); end
    exp_cmd_q.delete(); obs_cmd_q.delete();
  endtask

  task automatic test_text();
    send_byte(0, 8'h01);
    send_byte(0, 8'h80);
    send_byte(1, "a");
    send_byte(1, "b");
    send_nibble(1, 4'h6, 8);
    send_nibble(0, 4'h3, 8);   // mixed RS: high nibble's RS decides
    n_vec++;
    if (obs_clr != 1) begin n_err++; $display("FAIL text_clear: got %0d pulses expected 1", obs_clr); end
    n_vec++;
    if (obs_char_q.size() != exp_char_q.size()) begin
      n_err++; $display("FAIL text_char_count: got %0d expected %0d", obs_char_q.size(), exp_char_q.size());
    end
    for (int i = 0; i < exp_char_q.size() && i < obs_char_q.size(); i++) begin
      n_vec++;
      if (obs_char_q[i] !== exp_char_q[i]) begin
        n_err++; $display("FAIL text_char[%0d]: got %h expected %h", i, obs_char_q[i], exp_char_q[i]);
      end
    end
    exp_char_q.delete(); obs_char_q.delete(); exp_cmd_q.delete(); obs_cmd_q.delete();
    exp_clr = 0; obs_clr = 0;
  endtask

  task automatic test_addressing();
    send_byte(0, 8'hA7); send_byte(1, "x"); send_byte(1, "y");
    send_byte(0, 8'hE7); send_byte(1, "p"); send_byte(1, "q");
    send_byte(0, 8'h04); send_byte(0, 8'h80); send_byte(1, "d"); send_byte(1, "e");
    send_byte(0, 8'hC0); send_byte(1, "f"); send_byte(1, "g");
    send_byte(0, 8'h06);
    send_byte(0, 8'hB0); send_byte(1, "h");
    send_byte(0, 8'hF5); send_byte(1, "i");
    send_byte(0, 8'h8F); send_byte(1, "j"); send_byte(1, "k");
    send_byte(0, 8'h03); send_byte(1, "l");
    n_vec++;
    if (obs_char_q.size() != exp_char_q.size()) begin
      n_err++; $display("FAIL addr_char_count: got %0d expected %0d", obs_char_q.size(), exp_char_q.size());
    end
    for (int i = 0; i < exp_char_q.size() && i < obs_char_q.size(); i++) begin
      n_vec++;
      if (obs_char_q[i] !== exp_char_q[i]) begin
        n_err++; $display("FAIL addr_char[%0d]: got %h expected %h", i, obs_char_q[i], exp_char_q[i]);
      end
    end
    n_vec++;
    if (obs_cmd_q.size() != exp_cmd_q.size()) begin
      n_err++; $display("FAIL addr_cmd_count: got %0d expected %0d", obs_cmd_q.size(), exp_cmd_q.size());
    end
    exp_char_q.delete(); obs_char_q.delete(); exp_cmd_q.delete(); obs_cmd_q.delete();
  endtask

  task automatic test_dl_exit();
    send_byte(0, 8'h38);
    n_vec++;
    if (mode4 !== 1'b0) begin n_err++; $display("FAIL dl_exit_mode4: got %b expected 0", mode4); end
    send_nibble(1, 4'h2, 8);   // RS=1 in 8-bit mode is ignored
    send_nibble(0, 4'h2, 8);
    n_vec++;
    if (mode4 !== m_mode4) begin n_err++; $display("FAIL dl_reenter_mode4: got %b expected %b", mode4, m_mode4); end
    n_vec++;
    if (obs_cmd_q.size() != 1 || obs_char_q.size() != 0) begin
      n_err++; $display("FAIL dl_outputs: got %0d cmds %0d chars expected 1 and 0", obs_cmd_q.size(), obs_char_q.size());
    end
    exp_cmd_q.delete(); obs_cmd_q.delete(); exp_char_q.delete(); obs_char_q.delete();
  endtask

  task automatic test_timeout();
    send_nibble(1, 4'h4, 8);
    repeat (TO + 5) @(negedge CLK);
    m_hi_pend = 0;
    exp_fe++;
    n_vec++;
    if (obs_fe != exp_fe) begin n_err++; $display("FAIL timeout_frame_error: got %0d pulses expected %0d", obs_fe, exp_fe); end
    n_vec++;
    if (obs_char_q.size() != 0) begin n_err++; $display("FAIL timeout_no_char: got %0d chars expected 0", obs_char_q.size()); end
    send_byte(1, 8'h41);
    n_vec++;
    if (obs_char_q.size() != 1 || exp_char_q.size() != 1 || obs_char_q[0] !== exp_char_q[0]) begin
      n_err++; $display("FAIL timeout_recover: got %0d chars (first %h) expected one %h", obs_char_q.size(),
                        obs_char_q.size() ? obs_char_q[0] : 16'h0, exp_char_q.size() ? exp_char_q[0] : 16'h0);
    end
    n_vec++;
    if (obs_fe != exp_fe) begin n_err++; $display("FAIL timeout_fe_after: got %0d expected %0d", obs_fe, exp_fe); end
    exp_char_q.delete(); obs_char_q.delete(); exp_fe = 0; obs_fe = 0;
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit rs;
    for (int n = 0; n < 60; n++) begin
      rs = 1'($urandom_range(0, 1));
      b  = 8'($urandom_range(0, 255));
      if (!rs && b[7:4] == 4'h3) b = 8'h28;
      send_nibble(rs, b[7:4], $urandom_range(2, 30));
      send_nibble(rs, b[3:0], $urandom_range(2, 30));
    end
    n_vec++;
    if (obs_char_q.size() != exp_char_q.size()) begin
      n_err++; $display("FAIL rand_char_count: got %0d expected %0d", obs_char_q.size(), exp_char_q.size());
    end
    for (int i = 0; i < exp_char_q.size() && i < obs_char_q.size(); i++) begin
      n_vec++;
      if (obs_char_q[i] !== exp_char_q[i]) begin
        n_err++; $display("FAIL rand_char[%0d]: got %h expected %h", i, obs_char_q[i], exp_char_q[i]);
      end
    end
    n_vec++;
    if (obs_cmd_q.size() != exp_cmd_q.size()) begin
      n_err++; $display("FAIL rand_cmd_count: got %0d expected %0d", obs_cmd_q.size(), exp_cmd_q.size());
    end
    for (int i = 0; i < exp_cmd_q.size() && i < obs_cmd_q.size(); i++) begin
      n_vec++;
      if (obs_cmd_q[i] !== exp_cmd_q[i]) begin
        n_err++; $display("FAIL rand_cmd[%0d]: got %h expected %h", i, obs_cmd_q[i], exp_cmd_q[i]);
      end
    end
    n_vec++;
    if (obs_clr != exp_clr) begin n_err++; $display("FAIL rand_clear: got %0d expected %0d", obs_clr, exp_clr); end
    exp_char_q.delete(); obs_char_q.delete(); exp_cmd_q.delete(); obs_cmd_q.delete();
    exp_clr = 0; obs_clr = 0;
  endtask

  task automatic test_reset_mid_byte();
    send_nibble(0, 4'h2, 8);   // high nibble of 0x28 pending
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    send_nibble(0, 4'h8, 8);
    n_vec++;
    if (obs_cmd_q.size() != 0 || obs_char_q.size() != 0) begin
      n_err++; $display("FAIL midreset_outputs: got %0d cmds %0d chars expected 0", obs_cmd_q.size(), obs_char_q.size());
    end
    n_vec++;
    if (mode4 !== 1'b0) begin n_err++; $display("FAIL midreset_mode4: got %b expected 0", mode4); end
    n_vec++;
    if (fsm_state !== 2'd0) begin n_err++; $display("FAIL midreset_state: got %0d expected 0 (INIT8)", fsm_state); end
    send_nibble(0, 4'h2, 8);
    n_vec++;
    if (mode4 !== m_mode4) begin n_err++; $display("FAIL midreset_reenter: got %b expected %b", mode4, m_mode4); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0; n_err = 0;
    exp_clr = 0; obs_clr = 0; exp_fe = 0; obs_fe = 0;
    model_reset();
    test_reset();
    test_init();
    test_text();
    test_addressing();
    test_dl_exit();
    test_timeout();
    test_random();
    test_reset_mid_byte();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
